// File: rtl/simon_sched.sv
// Round-robin scheduler sharing one Simon core between two requesters.
// A job is launched by releasing the core from reset. It finishes on core_done or on a watchdog timeout.
module simon_sched #(
    parameter int unsigned N       = 16,
    parameter int unsigned M       = 4,
    parameter int unsigned TIMEOUT = 80
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic           req0_enc,
    input  logic [2*N-1:0] req0_din,
    input  logic [M*N-1:0] req0_key,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic           req1_enc,
    input  logic [2*N-1:0] req1_din,
    input  logic [M*N-1:0] req1_key,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic           resp_err,
    output logic [2*N-1:0] resp_data,
    output logic           core_rst_n,
    output logic           core_en_de_cry,
    output logic [2*N-1:0] core_din,
    output logic [M*N-1:0] core_key,
    input  logic [2*N-1:0] core_dout,
    input  logic           core_done
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StRun, StResp} state_e;

    state_e         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           core_rst_n_q, core_rst_n_d;
    logic           core_en_q, core_en_d;
    logic [2*N-1:0] core_din_q, core_din_d;
    logic [M*N-1:0] core_key_q, core_key_d;
    logic           resp_id_q, resp_id_d;
    logic           resp_err_q, resp_err_d;
    logic [2*N-1:0] resp_data_q, resp_data_d;

    logic gnt_idx;
    logic accept;

    // On contention the requester that was not served last wins.
    always_comb begin
        gnt_idx = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
        accept  = (state_q == StIdle) & (req0_valid | req1_valid);
    end

    assign req0_ready = accept & ~gnt_idx;
    assign req1_ready = accept & gnt_idx;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        core_rst_n_d = core_rst_n_q;
        core_en_d    = core_en_q;
        core_din_d   = core_din_q;
        core_key_d   = core_key_q;
        resp_id_d    = resp_id_q;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;
        case (state_q)
            StIdle: begin
                core_rst_n_d = 1'b0;
                if (accept) begin
                    core_en_d    = gnt_idx ? req1_enc : req0_enc;
                    core_din_d   = gnt_idx ? req1_din : req0_din;
                    core_key_d   = gnt_idx ? req1_key : req0_key;
                    resp_id_d    = gnt_idx;
                    last_grant_d = gnt_idx;
                    cnt_d        = '0;
                    core_rst_n_d = 1'b1;
                    state_d      = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_q + CW'(1);
                // core_done wins over a simultaneous timeout.
                if (core_done) begin
                    resp_data_d  = core_dout;
                    resp_err_d   = 1'b0;
                    core_rst_n_d = 1'b0;
                    state_d      = StResp;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    core_rst_n_d = 1'b0;
                    state_d      = StResp;
                end
            end
            StResp: begin
                core_rst_n_d = 1'b0;
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                core_rst_n_d = 1'b0;
                state_d      = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            core_rst_n_q <= 1'b0;
            core_en_q    <= 1'b0;
            core_din_q   <= '0;
            core_key_q   <= '0;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            core_rst_n_q <= core_rst_n_d;
            core_en_q    <= core_en_d;
            core_din_q   <= core_din_d;
            core_key_q   <= core_key_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid     = (state_q == StResp);
    assign resp_id        = resp_id_q;
    assign resp_err       = resp_err_q;
    assign resp_data      = resp_data_q;
    assign core_rst_n     = core_rst_n_q;
    assign core_en_de_cry = core_en_q;
    assign core_din       = core_din_q;
    assign core_key       = core_key_q;

endmodule
